// File: rtl/step_pulse_gen_pkg.sv
// Shared stepper definitions: controller state encoding and the step-period constant function.
package step_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MOVE = 2'd2
    } state_t;

    // Cycles per step for a speed code; 0 for the stop code. Elaboration-time use only.
    function automatic int unsigned period_cycles(
        input int unsigned clk_hz,
        input int unsigned rpm_step,
        input int unsigned steps_per_rev,
        input int unsigned code,
        input logic        half
    );
        longint unsigned p;
        p = 64'd0;
        if (code != 0) begin
            p = (64'(clk_hz) * 64'd60) / (64'(code) * 64'(rpm_step) * 64'(steps_per_rev));
        end
        if (half) begin
            p = p / 64'd2;
        end
        return 32'(p);
    endfunction

endpackage

// File: rtl/step_pulse_gen_step_rate_div.sv
// Step-rate divider: counts active cycles and flags the cycle that completes a period.
module step_rate_div #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             tick_c
);

    logic [CNT_W-1:0] cnt;

    // >= so that a shorter period selected mid-count fires at once
    assign tick_c = en && (cnt >= period - CNT_W'(1));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Stepper step-pulse generator: continuous RUN or counted MOVE, with direction,
// busy/done handshake, abort and a wrapping rotor position in half-step units.
module step_pulse_gen
    import step_pulse_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned STEPS_PER_REV = 200,
    parameter int unsigned RPM_STEP      = 10,
    parameter int unsigned SPEED_W       = 3,
    parameter int unsigned CNT_W         = 27,
    parameter int unsigned MOVE_W        = 10
) (
    input  logic                                   clk,
    input  logic                                   resetb,
    input  logic [SPEED_W-1:0]                     speed,
    input  logic                                   half_step,
    input  logic                                   dir,
    input  logic                                   run_en,
    input  logic                                   start,
    input  logic [MOVE_W-1:0]                      move_steps,
    input  logic                                   abort,
    output logic                                   step_pulse,
    output logic                                   dir_out,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(2*STEPS_PER_REV)-1:0]     pos
);

    localparam int          NCODE   = 1 << SPEED_W;
    localparam int unsigned POS_MOD = 2 * STEPS_PER_REV;
    localparam int unsigned PW      = $clog2(POS_MOD);

    state_t            state;
    logic [MOVE_W-1:0] rem;
    logic              mv_half;
    logic              mv_dir;

    logic [CNT_W-1:0]  per_full [NCODE];
    logic [CNT_W-1:0]  per_half [NCODE];

    logic              speed_nz;
    logic              half_sel;
    logic              dir_sel;
    logic              div_en;
    logic              div_clear;
    logic              tick;
    logic [CNT_W-1:0]  period;
    logic [PW-1:0]     delta;
    logic [PW-1:0]     pos_nx;

    // Constant period table per speed code
    for (genvar k = 0; k < NCODE; k++) begin : g_period
        assign per_full[k] = CNT_W'(period_cycles(CLK_HZ, RPM_STEP, STEPS_PER_REV, k, 1'b0));
        assign per_half[k] = CNT_W'(period_cycles(CLK_HZ, RPM_STEP, STEPS_PER_REV, k, 1'b1));
    end

    always_comb begin
        speed_nz = (speed != '0);
        half_sel = (state == ST_MOVE) ? mv_half : half_step;
        dir_sel  = (state == ST_MOVE) ? mv_dir  : dir;
        period   = half_sel ? per_half[speed] : per_full[speed];

        // A MOVE with rem==0 is the cycle its last pulse is visible; no further counting
        div_en    = ((state == ST_RUN)  && run_en && speed_nz) ||
                    ((state == ST_MOVE) && !abort && speed_nz && (rem != '0));
        div_clear = (state == ST_IDLE) ||
                    ((state == ST_RUN)  && !div_en) ||
                    ((state == ST_MOVE) && (abort || (rem == '0)));

        delta = half_sel ? PW'(1) : PW'(2);
        if (dir_sel) begin
            pos_nx = (pos < delta) ? pos + PW'(POS_MOD) - delta : pos - delta;
        end else begin
            pos_nx = (pos >= PW'(POS_MOD) - delta) ? pos + delta - PW'(POS_MOD) : pos + delta;
        end
    end

    step_rate_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk    (clk),
        .resetb (resetb),
        .clear  (div_clear),
        .en     (div_en),
        .period (period),
        .tick_c (tick)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_IDLE;
            rem        <= '0;
            mv_half    <= 1'b0;
            mv_dir     <= 1'b0;
            step_pulse <= 1'b0;
            dir_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pos        <= '0;
        end else begin
            step_pulse <= tick;
            done       <= 1'b0;
            if (tick) begin
                pos <= pos_nx;
            end

            case (state)
                ST_IDLE: begin
                    if (run_en && speed_nz) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        dir_out <= dir;
                    end else if (start) begin
                        if (move_steps == '0) begin
                            done <= 1'b1;
                        end else if (speed_nz) begin
                            state   <= ST_MOVE;
                            busy    <= 1'b1;
                            rem     <= move_steps;
                            mv_half <= half_step;
                            mv_dir  <= dir;
                            dir_out <= dir;
                        end
                    end
                end
                ST_RUN: begin
                    dir_out <= dir;
                    if (!run_en || !speed_nz) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_MOVE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (rem == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (tick) begin
                        rem <= rem - MOVE_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: reset/handshake vector table, timed corner sequences,
// and randomized stimulus against a cycle-level behavioural model.
module tb_step_pulse_gen;

    localparam int B_CLK_HZ = 2000;
    localparam int B_SPR    = 20;
    localparam int B_RPM    = 10;
    localparam int B_POSMOD = 2 * B_SPR;

    logic       clk;
    logic       resetb;
    logic [2:0] speed;
    logic       half_step;
    logic       dir;
    logic       run_en;
    logic       start;
    logic [9:0] move_steps;
    logic       abort;
    logic       step_pulse;
    logic       dir_out;
    logic       busy;
    logic       done;
    logic [5:0] pos;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    step_pulse_gen #(
        .CLK_HZ        (B_CLK_HZ),
        .STEPS_PER_REV (B_SPR),
        .RPM_STEP      (B_RPM),
        .SPEED_W       (3),
        .CNT_W         (12),
        .MOVE_W        (10)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .speed      (speed),
        .half_step  (half_step),
        .dir        (dir),
        .run_en     (run_en),
        .start      (start),
        .move_steps (move_steps),
        .abort      (abort),
        .step_pulse (step_pulse),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done),
        .pos        (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({step_pulse, dir_out, busy, done, pos});
    endfunction

    // ---------------- behavioural reference model ----------------
    int m_mode;    // 0 idle, 1 running, 2 counted move
    int m_elapsed; // active cycles spent in the current step period
    int m_left;
    bit m_half, m_dir;
    bit e_pulse, e_dir, e_busy, e_done;
    int e_pos;

    function automatic int ref_period(input int code, input bit half);
        int p;
        p = (B_CLK_HZ * 60) / (code * B_RPM * B_SPR);
        return half ? p / 2 : p;
    endfunction

    task automatic model_step();
        bit fire, h, d;
        fire = 0; h = 0; d = 0;
        e_done = 0;
        case (m_mode)
            0: begin
                if (run_en && speed != 0) begin
                    m_mode = 1; m_elapsed = 0; e_dir = dir;
                end else if (start) begin
                    if (move_steps == 0) e_done = 1;
                    else if (speed != 0) begin
                        m_mode = 2; m_elapsed = 0; m_left = int'(move_steps);
                        m_half = half_step; m_dir = dir; e_dir = dir;
                    end
                end
            end
            1: begin
                e_dir = dir;
                if (!run_en || speed == 0) begin
                    m_mode = 0; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed >= ref_period(int'(speed), half_step)) begin
                        fire = 1; m_elapsed = 0; h = half_step; d = dir;
                    end
                end
            end
            default: begin
                if (abort) begin
                    m_mode = 0; m_elapsed = 0;
                end else if (m_left == 0) begin
                    m_mode = 0; e_done = 1;
                end else if (speed != 0) begin
                    m_elapsed++;
                    if (m_elapsed >= ref_period(int'(speed), m_half)) begin
                        fire = 1; m_elapsed = 0; m_left--; h = m_half; d = m_dir;
                    end
                end
            end
        endcase
        if (fire) e_pos = (e_pos + (d ? -1 : 1) * (h ? 1 : 2) + B_POSMOD) % B_POSMOD;
        e_pulse = fire;
        e_busy  = (m_mode != 0);
    endtask

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_mode = 0; m_elapsed = 0; m_left = 0; m_half = 0; m_dir = 0;
            e_pulse = 0; e_dir = 0; e_busy = 0; e_done = 0; e_pos = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_on)
            chk("model_outputs", outs(), int'({e_pulse, e_dir, e_busy, e_done, 6'(e_pos)}));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        run_en = 0; start = 0; abort = 0; move_steps = '0; speed = '0; half_step = 0; dir = 0;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        idle_inputs();
        @(posedge clk); @(posedge clk); #1;
        resetb = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       run_en, start, abort, half, dir;
        logic [2:0] speed;
        logic [9:0] steps;
        logic       e_busy, e_done, e_dir;
    } vec_t;

    vec_t vecs [12];

    int npulse, first, last, spacing_ok, done_n, busy_at_done, p1, p20, extra_p, extra_d;
    int times [4];

    initial begin
        resetb = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        chk_on = 1;
        chk("reset_outputs", outs(), 0);
        @(posedge clk); #1;
        resetb = 1'b1;

        // run  start abort half dir  speed steps  busy done dir
        vecs[0]  = '{0, 0, 0, 0, 0, 3'd0, 10'd0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 3'd6, 10'd0, 0, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 3'd6, 10'd0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0, 3'd0, 10'd3, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 1, 3'd0, 10'd0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 1, 3'd6, 10'd0, 1, 0, 1};
        vecs[6]  = '{1, 1, 1, 0, 0, 3'd6, 10'd4, 1, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 1, 3'd6, 10'd0, 0, 0, 1};
        vecs[8]  = '{0, 1, 0, 1, 0, 3'd3, 10'd2, 1, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 1, 3'd3, 10'd0, 1, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 1, 3'd3, 10'd0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 3'd3, 10'd0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            run_en = vecs[i].run_en; start = vecs[i].start; abort = vecs[i].abort;
            half_step = vecs[i].half; dir = vecs[i].dir; speed = vecs[i].speed;
            move_steps = vecs[i].steps;
            cyc();
            chk($sformatf("vec%0d", i), outs(),
                int'({1'b0, vecs[i].e_dir, vecs[i].e_busy, vecs[i].e_done, 6'd0}));
        end

        // RUN code 6 full step: period 100, pos wraps after 20 pulses
        do_reset();
        run_en = 1; speed = 3'd6;
        cyc();
        chk("run_busy", int'(busy), 1);
        npulse = 0; first = -1; last = 0; spacing_ok = 1; p1 = -1; p20 = -1;
        for (int n = 1; n <= 2100; n++) begin
            cyc();
            if (step_pulse) begin
                npulse++;
                if (npulse == 1) begin first = n; p1 = int'(pos); end
                else if (n - last != 100) spacing_ok = 0;
                if (npulse == 20) p20 = int'(pos);
                last = n;
            end
        end
        chk("run_first_pulse", first, 100);
        chk("run_spacing", spacing_ok, 1);
        chk("run_count", npulse, 21);
        chk("run_pos1", p1, 2);
        chk("run_pos_wrap", p20, 0);
        run_en = 0;
        cyc();
        chk("run_stop_busy", int'(busy), 0);

        // MOVE 5 half steps at code 6
        do_reset();
        start = 1; move_steps = 10'd5; speed = 3'd6; half_step = 1;
        cyc();
        start = 0;
        npulse = 0; first = -1; last = 0; spacing_ok = 1; done_n = -1; busy_at_done = -1;
        for (int n = 1; n <= 400; n++) begin
            cyc();
            if (step_pulse) begin
                npulse++;
                if (npulse == 1) first = n; else if (n - last != 50) spacing_ok = 0;
                last = n;
            end
            if (done && done_n < 0) begin done_n = n; busy_at_done = int'(busy); end
        end
        chk("move5_first", first, 50);
        chk("move5_spacing", spacing_ok, 1);
        chk("move5_count", npulse, 5);
        chk("move5_done_cycle", done_n, 251);
        chk("move5_busy_at_done", busy_at_done, 0);
        chk("move5_pos", int'(pos), 5);

        // MOVE 10 full reverse, abort after 2 pulses
        do_reset();
        start = 1; move_steps = 10'd10; speed = 3'd6; dir = 1;
        cyc();
        start = 0;
        npulse = 0; p1 = -1;
        for (int n = 1; n <= 300 && npulse < 2; n++) begin
            cyc();
            if (step_pulse) begin npulse++; if (npulse == 1) p1 = int'(pos); end
        end
        chk("abort_pulses_seen", npulse, 2);
        chk("abort_pos_wrap_rev", p1, 38);
        abort = 1;
        cyc();
        abort = 0;
        chk("abort_busy", int'(busy), 0);
        extra_p = 0; extra_d = 0;
        for (int n = 0; n < 300; n++) begin
            cyc();
            extra_p += int'(step_pulse);
            extra_d += int'(done);
        end
        chk("abort_no_more_pulses", extra_p, 0);
        chk("abort_no_done", extra_d, 0);
        chk("abort_pos", int'(pos), 36);

        // Abort in the cycle the last pulse is visible
        do_reset();
        start = 1; move_steps = 10'd2; speed = 3'd6;
        cyc();
        start = 0;
        npulse = 0;
        for (int n = 1; n <= 300 && npulse < 2; n++) begin
            cyc();
            npulse += int'(step_pulse);
        end
        chk("lastabort_pulses", npulse, 2);
        abort = 1;
        cyc();
        abort = 0;
        chk("lastabort_busy", int'(busy), 0);
        extra_d = int'(done);
        repeat (5) begin cyc(); extra_d += int'(done); end
        chk("lastabort_no_done", extra_d, 0);
        chk("lastabort_pos", int'(pos), 4);

        // Speed increase mid-period: code 1 -> 6 at count 300
        do_reset();
        run_en = 1; speed = 3'd1;
        cyc();
        npulse = 0;
        repeat (300) begin cyc(); npulse += int'(step_pulse); end
        chk("speedup_none_early", npulse, 0);
        speed = 3'd6;
        npulse = 0;
        for (int n = 301; n <= 520; n++) begin
            cyc();
            if (step_pulse) begin
                if (npulse < 4) times[npulse] = n;
                npulse++;
            end
        end
        chk("speedup_count", npulse, 3);
        chk("speedup_first", times[0], 301);
        chk("speedup_second", times[1], 401);
        run_en = 0;
        cyc();

        // speed 0 pauses a MOVE; remaining count and divider held
        do_reset();
        start = 1; move_steps = 10'd3; speed = 3'd6;
        cyc();
        start = 0;
        npulse = 0; done_n = -1;
        for (int n = 1; n <= 600; n++) begin
            if (n == 51)  speed = 3'd0;
            if (n == 251) speed = 3'd6;
            cyc();
            if (step_pulse) begin
                if (npulse < 4) times[npulse] = n;
                npulse++;
            end
            if (done && done_n < 0) done_n = n;
        end
        chk("pause_count", npulse, 3);
        chk("pause_first", times[0], 300);
        chk("pause_third", times[2], 500);
        chk("pause_done", done_n, 501);

        // Reset in the middle of a MOVE
        do_reset();
        start = 1; move_steps = 10'd10; speed = 3'd6; half_step = 1;
        cyc();
        start = 0;
        npulse = 0;
        for (int n = 1; n <= 100 && npulse < 1; n++) begin
            cyc();
            npulse += int'(step_pulse);
        end
        chk("midreset_pulse_seen", npulse, 1);
        cyc();
        resetb = 0;
        #1;
        chk("midreset_outputs_low", outs(), 0);
        cyc();
        chk("midreset_outputs_held", outs(), 0);
        resetb = 1;
        npulse = 0; extra_d = 0;
        repeat (300) begin
            cyc();
            npulse += int'(step_pulse);
            extra_d += int'(busy);
        end
        chk("midreset_no_pulse", npulse, 0);
        chk("midreset_idle", extra_d, 0);

        // Randomized traffic checked against the model every cycle
        do_reset();
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(299) == 0) run_en = ~run_en;
            if ($urandom_range(99) == 0)
                speed = ($urandom_range(3) == 0) ? 3'($urandom_range(3)) : 3'($urandom_range(7, 4));
            if ($urandom_range(49) == 0) half_step = ~half_step;
            if ($urandom_range(49) == 0) dir = ~dir;
            start = ($urandom_range(79) == 0);
            move_steps = 10'($urandom_range(6));
            abort = ($urandom_range(499) == 0);
            cyc();
        end
        idle_inputs();
        cyc();

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
